// File: rtl/vert_timing_if.sv
// rtl/vert_timing_if.sv - line-rate handshake between horizontal and vertical timing stages
interface vert_timing_if #(
    parameter int LW = 10
) ();
    logic          lineEnd;
    logic          hDataValid;
    logic [LW-1:0] lineNum;
    logic          vsync;
    logic          vDataValid;
    logic          frameStart;
    logic          pixelValid;

    modport master (
        output lineEnd,
        output hDataValid,
        input  lineNum,
        input  vsync,
        input  vDataValid,
        input  frameStart,
        input  pixelValid
    );

    modport slave (
        input  lineEnd,
        input  hDataValid,
        output lineNum,
        output vsync,
        output vDataValid,
        output frameStart,
        output pixelValid
    );
endinterface

// File: rtl/vert_timing.sv
// rtl/vert_timing.sv - vertical timing generator: line counter, vsync, data-valid, frame start
module vert_timing #(
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic        pixelClk,
    input  logic        rst,
    vert_timing_if.slave tif
);
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int LW      = $clog2(V_TOTAL);

    // Last line of each region; the FSM leaves the region on the lineEnd of that line.
    localparam logic [LW-1:0] VIS_LAST  = LW'(V_VISIBLE - 1);
    localparam logic [LW-1:0] FP_LAST   = LW'(V_VISIBLE + V_FRONT - 1);
    localparam logic [LW-1:0] SYNC_LAST = LW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [LW-1:0] BP_LAST   = LW'(V_TOTAL - 1);

    if (V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_param
        $error("vert_timing: every V_* parameter must be >= 1");
    end

    typedef enum logic [1:0] {
        S_VIS  = 2'd0,
        S_FP   = 2'd1,
        S_SYNC = 2'd2,
        S_BP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] line;
    logic [LW-1:0] line_nxt;
    logic          wrap;
    logic          vsync_q;
    logic          vdv_q;
    logic          fs_q;
    logic          pv_q;

    // Next line/state: only a lineEnd advances; the BP exit is the only wrap point.
    always_comb begin
        state_nxt = state;
        line_nxt  = line;
        wrap      = 1'b0;
        if (tif.lineEnd) begin
            line_nxt = line + 1'b1;
            case (state)
                S_VIS:  if (line == VIS_LAST)  state_nxt = S_FP;
                S_FP:   if (line == FP_LAST)   state_nxt = S_SYNC;
                S_SYNC: if (line == SYNC_LAST) state_nxt = S_BP;
                S_BP: begin
                    if (line == BP_LAST) begin
                        state_nxt = S_VIS;
                        line_nxt  = '0;
                        wrap      = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_VIS;
                    line_nxt  = '0;
                end
            endcase
        end
    end

    // State and line registers.
    always_ff @(posedge pixelClk or negedge rst) begin
        if (!rst) begin
            state <= S_VIS;
            line  <= '0;
        end else begin
            state <= state_nxt;
            line  <= line_nxt;
        end
    end

    // Outputs decoded from the next state so they switch on the same edge as the line count.
    always_ff @(posedge pixelClk or negedge rst) begin
        if (!rst) begin
            vsync_q <= ~SYNC_POL;
            vdv_q   <= 1'b1;
            fs_q    <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            vsync_q <= (state_nxt == S_SYNC) ? SYNC_POL : ~SYNC_POL;
            vdv_q   <= (state_nxt == S_VIS);
            fs_q    <= wrap;
            pv_q    <= tif.hDataValid & vdv_q;
        end
    end

    assign tif.lineNum    = line;
    assign tif.vsync      = vsync_q;
    assign tif.vDataValid = vdv_q;
    assign tif.frameStart = fs_q;
    assign tif.pixelValid = pv_q;
endmodule

// File: tb/tb_vert_timing.sv
// tb/tb_vert_timing.sv - self-checking bench for vert_timing
module tb_vert_timing;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = 525;
    localparam int LW        = 10;

    logic pixelClk = 1'b0;
    logic rst      = 1'b0;
    logic le       = 1'b0;
    logic hdv      = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int fs_seen = 0;

    vert_timing_if #(.LW(LW)) bus0 ();
    vert_timing_if #(.LW(LW)) bus1 ();

    assign bus0.lineEnd    = le;
    assign bus0.hDataValid = hdv;
    assign bus1.lineEnd    = le;
    assign bus1.hDataValid = hdv;

    vert_timing #(
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .SYNC_POL(1'b0)
    ) dut0 (
        .pixelClk(pixelClk),
        .rst(rst),
        .tif(bus0.slave)
    );

    vert_timing #(
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .SYNC_POL(1'b1)
    ) dut1 (
        .pixelClk(pixelClk),
        .rst(rst),
        .tif(bus1.slave)
    );

    always #20 pixelClk = ~pixelClk;

    // Reference model: a plain line counter modulo V_TOTAL; everything else derives from it.
    int   m_line;
    logic m_fs;
    logic m_pv;

    function automatic logic exp_vs(input int line, input bit pol);
        if (line >= V_VISIBLE + V_FRONT && line < V_VISIBLE + V_FRONT + V_SYNC)
            return pol;
        return ~pol;
    endfunction

    always @(posedge pixelClk or negedge rst) begin
        if (!rst) begin
            m_line <= 0;
            m_fs   <= 1'b0;
            m_pv   <= 1'b0;
        end else begin
            m_pv <= hdv && (m_line < V_VISIBLE);
            if (le) begin
                m_line <= (m_line + 1) % V_TOTAL;
                m_fs   <= (m_line == V_TOTAL - 1);
            end else begin
                m_fs <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge pixelClk) begin
        if (rst) begin
            chk("lineNum0",    32'(bus0.lineNum),    32'(m_line));
            chk("lineNum1",    32'(bus1.lineNum),    32'(m_line));
            chk("vsync0",      32'(bus0.vsync),      32'(exp_vs(m_line, 1'b0)));
            chk("vsync1",      32'(bus1.vsync),      32'(exp_vs(m_line, 1'b1)));
            chk("vDataValid0", 32'(bus0.vDataValid), 32'(m_line < V_VISIBLE));
            chk("vDataValid1", 32'(bus1.vDataValid), 32'(m_line < V_VISIBLE));
            chk("frameStart0", 32'(bus0.frameStart), 32'(m_fs));
            chk("frameStart1", 32'(bus1.frameStart), 32'(m_fs));
            chk("pixelValid0", 32'(bus0.pixelValid), 32'(m_pv));
            chk("pixelValid1", 32'(bus1.pixelValid), 32'(m_pv));
            if (bus0.frameStart) fs_seen++;
        end
    end

    task automatic tick();
        @(posedge pixelClk);
        #1;
    endtask

    task automatic pulse(input int gap);
        le = 1'b1;
        tick();
        le = 1'b0;
        repeat (gap - 1) tick();
    endtask

    int vdv_cnt, vs_lo0, vs_hi1, first_lo, fs_before;
    int fs_cnt, fs_first, fs_last;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_lineNum",    32'(bus0.lineNum),    32'd0);
        chk("rst_vDataValid", 32'(bus0.vDataValid), 32'd1);
        chk("rst_vsync0",     32'(bus0.vsync),      32'd1);
        chk("rst_vsync1",     32'(bus1.vsync),      32'd0);
        chk("rst_frameStart", 32'(bus0.frameStart), 32'd0);
        chk("rst_pixelValid", 32'(bus0.pixelValid), 32'd0);
        rst = 1'b1;
        tick();

        // Test 1 + 5: one frame of spaced pulses, both sync polarities
        vdv_cnt = 0; vs_lo0 = 0; vs_hi1 = 0; first_lo = -1;
        fs_before = fs_seen;
        for (int i = 0; i < V_TOTAL; i++) begin
            pulse(8);
            vdv_cnt += int'(bus0.vDataValid);
            if (bus0.vsync == 1'b0) begin
                vs_lo0++;
                if (first_lo < 0) first_lo = int'(bus0.lineNum);
            end
            vs_hi1 += int'(bus1.vsync);
        end
        chk("t1_vdv_lines",     32'(vdv_cnt), 32'd480);
        chk("t1_vsync_lines",   32'(vs_lo0), 32'd2);
        chk("t1_vsync_first",   32'(first_lo), 32'd490);
        chk("t5_vsync1_lines",  32'(vs_hi1), 32'd2);
        chk("t1_wrap_line",     32'(bus0.lineNum), 32'd0);
        chk("t1_fs_count",      32'(fs_seen - fs_before), 32'd1);

        // Test 2: back-to-back lineEnd for two frames
        fs_cnt = 0; fs_first = -1; fs_last = -1;
        le = 1'b1;
        for (int i = 0; i < 2 * V_TOTAL; i++) begin
            tick();
            if (bus0.frameStart) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                fs_last = i;
            end
        end
        le = 1'b0;
        chk("t2_fs_count",   32'(fs_cnt), 32'd2);
        chk("t2_fs_spacing", 32'(fs_last - fs_first), 32'd525);
        chk("t2_fs_first",   32'(fs_first), 32'd524);
        chk("t2_end_line",   32'(bus0.lineNum), 32'd0);
        tick();

        // Test 3: asynchronous reset mid-frame
        repeat (300) pulse(2);
        chk("t3_pre_line", 32'(bus0.lineNum), 32'd300);
        #4 rst = 1'b0;
        #1;
        chk("t3_async_line",  32'(bus0.lineNum),    32'd0);
        chk("t3_async_vdv",   32'(bus0.vDataValid), 32'd1);
        chk("t3_async_vs0",   32'(bus0.vsync),      32'd1);
        chk("t3_async_vs1",   32'(bus1.vsync),      32'd0);
        #5 rst = 1'b1;
        tick();
        pulse(1);
        chk("t3_first_line", 32'(bus0.lineNum), 32'd1);

        // Test 4: hDataValid across the last visible line and first porch line
        repeat (478) pulse(1);
        chk("t4_line479", 32'(bus0.lineNum), 32'd479);
        hdv = 1'b1; tick();
        chk("t4_pv_a", 32'(bus0.pixelValid), 32'd1);
        hdv = 1'b0; tick();
        chk("t4_pv_b", 32'(bus0.pixelValid), 32'd0);
        hdv = 1'b1; tick();
        chk("t4_pv_c", 32'(bus0.pixelValid), 32'd1);
        le = 1'b1; tick(); le = 1'b0;
        chk("t4_line480", 32'(bus0.lineNum), 32'd480);
        chk("t4_pv_d",    32'(bus0.pixelValid), 32'd1);
        tick();
        chk("t4_pv_e", 32'(bus0.pixelValid), 32'd0);
        hdv = 1'b0; tick();
        hdv = 1'b1; tick();
        chk("t4_pv_f", 32'(bus0.pixelValid), 32'd0);
        hdv = 1'b0;

        // Test 6: long idle inside the sync region
        repeat (11) pulse(1);
        chk("t6_pre_line", 32'(bus0.lineNum), 32'd491);
        repeat (10000) tick();
        chk("t6_line", 32'(bus0.lineNum),    32'd491);
        chk("t6_vs0",  32'(bus0.vsync),      32'd0);
        chk("t6_vs1",  32'(bus1.vsync),      32'd1);
        chk("t6_vdv",  32'(bus0.vDataValid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
